// File: rtl/layer_sequencer.sv
// Sequencer for one fully-connected layer: buffers an input vector, broadcasts it as one
// gap-free burst, gathers per-neuron results and serialises them downstream.
module layer_sequencer #(
    parameter int INPUTS_NUM     = 784,
    parameter int NEURONS_NUM    = 30,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             i_data_in,
    input  logic                              i_data_in_valid,
    output logic                              o_data_in_ready,
    output logic [DATA_WIDTH-1:0]             o_neuron_data,
    output logic                              o_neuron_data_valid,
    input  logic [NEURONS_NUM*DATA_WIDTH-1:0] i_neuron_out,
    input  logic [NEURONS_NUM-1:0]            i_neuron_out_valid,
    output logic [DATA_WIDTH-1:0]             o_data_out,
    output logic                              o_data_out_valid,
    input  logic                              i_data_out_ready,
    output logic                              o_busy,
    output logic                              o_error
);

    localparam int MAX_IO = (INPUTS_NUM > NEURONS_NUM) ? INPUTS_NUM : NEURONS_NUM;
    localparam int MAX_ALL = (MAX_IO > TIMEOUT_CYCLES) ? MAX_IO : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_ALL + 1);
    localparam int IN_AW = (INPUTS_NUM > 1) ? $clog2(INPUTS_NUM) : 1;
    localparam int OUT_AW = (NEURONS_NUM > 1) ? $clog2(NEURONS_NUM) : 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic [DATA_WIDTH-1:0]  inbuf_r      [INPUTS_NUM];
    logic [DATA_WIDTH-1:0]  outbuf_r     [NEURONS_NUM];
    logic [DATA_WIDTH-1:0]  outbuf_next_s[NEURONS_NUM];
    logic [NEURONS_NUM-1:0] flags_r;
    logic [NEURONS_NUM-1:0] flags_next_s;

    logic [CNT_W-1:0] wr_cnt_r;
    logic [CNT_W-1:0] str_cnt_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic [CNT_W-1:0] rd_cnt_r;
    logic [CNT_W-1:0] rd_cnt_inc_s;

    logic in_accept_s;
    logic last_in_s;
    logic stream_end_s;
    logic all_done_s;
    logic timeout_s;
    logic out_accept_s;
    logic last_out_s;

    logic                  ready_r;
    logic [DATA_WIDTH-1:0] nd_r;
    logic                  nd_valid_r;
    logic [DATA_WIDTH-1:0] dout_r;
    logic                  dout_valid_r;
    logic                  busy_r;
    logic                  error_r;

    assign o_data_in_ready     = ready_r;
    assign o_neuron_data       = nd_r;
    assign o_neuron_data_valid = nd_valid_r;
    assign o_data_out          = dout_r;
    assign o_data_out_valid    = dout_valid_r;
    assign o_busy              = busy_r;
    assign o_error             = error_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Handshake decode, result capture merge and next-state logic.
    always_comb begin
        next_state_s = state_r;
        in_accept_s  = i_data_in_valid && ready_r;
        last_in_s    = in_accept_s && (wr_cnt_r == CNT_W'(INPUTS_NUM - 1));
        stream_end_s = (str_cnt_r == CNT_W'(INPUTS_NUM));
        out_accept_s = dout_valid_r && i_data_out_ready;
        last_out_s   = out_accept_s && (rd_cnt_r == CNT_W'(NEURONS_NUM - 1));
        rd_cnt_inc_s = rd_cnt_r + CNT_W'(1);

        if (state_r == ST_WAIT) begin
            flags_next_s = flags_r | i_neuron_out_valid;
        end else begin
            flags_next_s = flags_r;
        end
        all_done_s = &flags_next_s;
        timeout_s  = (state_r == ST_WAIT) && !all_done_s &&
                     (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

        // Missing results are forced to zero on timeout so DRAIN never emits stale data.
        for (int j = 0; j < NEURONS_NUM; j++) begin
            if ((state_r == ST_WAIT) && i_neuron_out_valid[j]) begin
                outbuf_next_s[j] = i_neuron_out[j*DATA_WIDTH +: DATA_WIDTH];
            end else if (timeout_s && !flags_next_s[j]) begin
                outbuf_next_s[j] = '0;
            end else begin
                outbuf_next_s[j] = outbuf_r[j];
            end
        end

        case (state_r)
            ST_LOAD: begin
                if (last_in_s) begin
                    next_state_s = ST_STREAM;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_STREAM: begin
                if (stream_end_s) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_STREAM;
                end
            end
            ST_WAIT: begin
                if (all_done_s || timeout_s) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (last_out_s) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_LOAD;
            end
        endcase
    end

    // Input buffer write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (in_accept_s) begin
            inbuf_r[wr_cnt_r[IN_AW-1:0]] <= i_data_in;
        end
    end

    // Result buffer; only changes while collecting results.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NEURONS_NUM; j++) begin
            outbuf_r[j] <= outbuf_next_s[j];
        end
    end

    // Counters, flags and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_r     <= '0;
            str_cnt_r    <= '0;
            tmo_cnt_r    <= '0;
            rd_cnt_r     <= '0;
            flags_r      <= '0;
            ready_r      <= 1'b1;
            nd_r         <= '0;
            nd_valid_r   <= 1'b0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            ready_r <= (next_state_s == ST_LOAD);
            busy_r  <= (next_state_s != ST_LOAD);
            if (timeout_s) begin
                error_r <= 1'b1;
            end
            case (state_r)
                ST_LOAD: begin
                    if (in_accept_s) begin
                        wr_cnt_r <= wr_cnt_r + CNT_W'(1);
                    end
                    // Prime the read so the first broadcast word follows the last accept directly.
                    if (last_in_s) begin
                        nd_r       <= inbuf_r[IN_AW'(0)];
                        nd_valid_r <= 1'b1;
                        str_cnt_r  <= CNT_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (stream_end_s) begin
                        nd_valid_r <= 1'b0;
                        tmo_cnt_r  <= '0;
                    end else begin
                        nd_r      <= inbuf_r[str_cnt_r[IN_AW-1:0]];
                        str_cnt_r <= str_cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    flags_r <= flags_next_s;
                    if (all_done_s || timeout_s) begin
                        dout_r       <= outbuf_next_s[OUT_AW'(0)];
                        dout_valid_r <= 1'b1;
                        rd_cnt_r     <= '0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (last_out_s) begin
                        dout_valid_r <= 1'b0;
                        flags_r      <= '0;
                        wr_cnt_r     <= '0;
                    end else if (out_accept_s) begin
                        rd_cnt_r <= rd_cnt_inc_s;
                        dout_r   <= outbuf_r[rd_cnt_inc_s[OUT_AW-1:0]];
                    end
                end
                default: begin
                    wr_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule
